// File: rtl/datamem_arbiter.sv
// -----------------------------------------------------------------------------
// datamem_arbiter
//
// Shares one single-port data memory between the pipeline (core port) and a
// host/loader (dbg port). Each access takes three cycles:
//   IDLE  : requests sampled, winner's we/addr/wdata latched
//   ISSUE : memory strobed from the latched values
//   RESP  : winner's ack pulses; on a read, the winner's rdata takes mem_rdata
// When both requesters are eligible, the one that was not granted last wins.
// The core is masked while halt is high. A core access that is already in
// flight when halt rises still completes.
//
// Optional feature (macro ARB_STALLCNT_EN): adds output stall_count, a 16-bit
// saturating count of the cycles with core_stall=1. Without the macro the port
// and the counter do not exist.
//
// Ports
//   clk                         clock, rising edge
//   reset                       asynchronous, active-low reset
//   halt                        masks core requests while high
//   core_req/we/addr/wdata      pipeline request
//   core_ack/rdata/stall        pipeline response; stall = req && !ack
//   dbg_req/we/addr/wdata       host request
//   dbg_ack/rdata               host response
//   mem_en/we/addr/wdata        memory command (active in ISSUE only)
//   mem_rdata                   memory read data, valid the cycle after mem_en
//   stall_count                 (ARB_STALLCNT_EN only) saturating stall count
// -----------------------------------------------------------------------------
module datamem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [15:0] core_addr,
    input  logic [15:0] core_wdata,
    output logic        core_ack,
    output logic [15:0] core_rdata,
    output logic        core_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [15:0] dbg_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
`ifdef ARB_STALLCNT_EN
    ,
    output logic [15:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        start_s;

    logic        core_elig_s;
    logic        dbg_elig_s;
    logic        any_elig_s;
    logic        grant_dbg_s;
    logic        sel_we_s;
    logic [15:0] sel_addr_s;
    logic [15:0] sel_wdata_s;

    // Latched transaction; mem_addr_r/mem_wdata_r double as the address/data latch
    logic        we_r;
    logic        win_dbg_r;
    logic        last_dbg_r;    // 1 = dbg was granted last, so core wins the next tie
    logic        mem_en_r;
    logic        mem_we_r;
    logic [15:0] mem_addr_r;
    logic [15:0] mem_wdata_r;

    logic        core_ack_r;
    logic        dbg_ack_r;
    logic [15:0] core_rdata_r;
    logic [15:0] dbg_rdata_r;
    logic        rd_resp_s;
    logic        core_stall_s;

    assign core_elig_s = core_req & ~halt;
    assign dbg_elig_s  = dbg_req;
    assign any_elig_s  = core_elig_s | dbg_elig_s;

    // Pick the winner (round-robin on a tie) and route its request fields
    always_comb begin
        grant_dbg_s = 1'b0;
        sel_we_s    = 1'b0;
        sel_addr_s  = 16'h0000;
        sel_wdata_s = 16'h0000;
        if (core_elig_s && dbg_elig_s) begin
            grant_dbg_s = ~last_dbg_r;
        end else if (dbg_elig_s) begin
            grant_dbg_s = 1'b1;
        end else begin
            grant_dbg_s = 1'b0;
        end
        if (grant_dbg_s) begin
            sel_we_s    = dbg_we;
            sel_addr_s  = dbg_addr;
            sel_wdata_s = dbg_wdata;
        end else begin
            sel_we_s    = core_we;
            sel_addr_s  = core_addr;
            sel_wdata_s = core_wdata;
        end
    end

    // Next-state logic; start_s marks the IDLE->ISSUE edge where the winner is latched
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_elig_s) begin
                    state_next_s = ISSUE;
                    start_s      = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE:   state_next_s = RESP;
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Latch the winner and drive the memory command for exactly the ISSUE cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 16'h0000;
            mem_wdata_r <= 16'h0000;
            we_r        <= 1'b0;
            win_dbg_r   <= 1'b0;
            last_dbg_r  <= 1'b1;
        end else if (start_s) begin
            mem_en_r    <= 1'b1;
            mem_we_r    <= sel_we_s;
            mem_addr_r  <= sel_addr_s;
            mem_wdata_r <= sel_wdata_s;
            we_r        <= sel_we_s;
            win_dbg_r   <= grant_dbg_s;
            last_dbg_r  <= grant_dbg_s;
        end else begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
        end
    end

    // One-cycle ack to the winner during RESP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_ack_r <= 1'b0;
            dbg_ack_r  <= 1'b0;
        end else begin
            core_ack_r <= (state_r == ISSUE) && !win_dbg_r;
            dbg_ack_r  <= (state_r == ISSUE) &&  win_dbg_r;
        end
    end

    assign rd_resp_s = (state_r == RESP) && !we_r;

    // Read data registers: capture mem_rdata at the end of a read RESP, hold otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_rdata_r <= 16'h0000;
            dbg_rdata_r  <= 16'h0000;
        end else if (rd_resp_s) begin
            if (win_dbg_r) begin
                dbg_rdata_r <= mem_rdata;
            end else begin
                core_rdata_r <= mem_rdata;
            end
        end else begin
            core_rdata_r <= core_rdata_r;
            dbg_rdata_r  <= dbg_rdata_r;
        end
    end

    // mem_rdata only arrives in RESP, so it is forwarded alongside the ack
    // and the register carries the value from the following cycle onward.
    assign core_rdata   = (rd_resp_s && !win_dbg_r) ? mem_rdata : core_rdata_r;
    assign dbg_rdata    = (rd_resp_s &&  win_dbg_r) ? mem_rdata : dbg_rdata_r;
    assign core_ack     = core_ack_r;
    assign dbg_ack      = dbg_ack_r;
    assign core_stall_s = core_req & ~core_ack_r;
    assign core_stall   = core_stall_s;
    assign mem_en       = mem_en_r;
    assign mem_we       = mem_we_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;

`ifdef ARB_STALLCNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of cycles the core spends stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= 16'h0000;
        end else if (core_stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_count = stall_cnt_r;
`endif

endmodule

// File: doc/datamem_arbiter.md
DATAMEM_ARBITER -- requirements
Module: datamem_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: halt  input  1  processor halted; core requests are masked while high.
REQ-004 SHALL have ports: core_req in 1, core_we in 1, core_addr in 16, core_wdata in 16  pipeline load/store request.
REQ-005 SHALL have ports: core_ack out 1, core_rdata out 16, core_stall out 1  pipeline response and stall.
REQ-006 SHALL have ports: dbg_req in 1, dbg_we in 1, dbg_addr in 16, dbg_wdata in 16, dbg_ack out 1, dbg_rdata out 16  host/loader port.
REQ-007 SHALL have ports: mem_en out 1, mem_we out 1, mem_addr out 16, mem_wdata out 16, mem_rdata in 16  single-port data memory; rdata is valid the cycle after mem_en.

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE and RESP; transitions SHALL be IDLE->ISSUE on any eligible request, ISSUE->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-009 SHALL sample requests only in IDLE; eligible = dbg_req, or core_req && !halt.
REQ-010 SHALL latch we/addr/wdata of the winner on the IDLE->ISSUE edge; requester input changes during ISSUE/RESP SHALL be ignored.
REQ-011 SHALL hold a 1-bit last-grant pointer; with both requests eligible, the requester not last granted wins; a single eligible requester always wins.
REQ-012 SHALL drive mem_en=1, mem_we, mem_addr and mem_wdata from latched values in ISSUE only; mem_en=0, mem_we=0 otherwise.
REQ-013 SHALL pulse the winner's ack for exactly one cycle in RESP; latency = request sampled in cycle N -> mem_en in N+1 -> ack in N+2.
REQ-014 SHALL, on read, load the winner's rdata register from mem_rdata in RESP; on write, the rdata register SHALL hold its previous value.
REQ-015 SHALL drive core_stall = core_req && !core_ack combinationally.
REQ-016 Requester SHALL drop req on the edge sampling ack; req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-017 SHALL complete an in-flight core transaction if halt rises during ISSUE/RESP.
REQ-018 Maximum throughput SHALL be one access per 3 cycles; addresses wrap naturally at 16 bits (0xFFFF valid).

Reset
REQ-019 SHALL on reset low immediately force: state=IDLE, last-grant=dbg (core wins first tie), all ack/mem_en/mem_we=0, mem_addr/mem_wdata=0, core_rdata/dbg_rdata=0.
REQ-020 SHALL discard any in-flight access on reset mid-operation; no ack SHALL be issued for it.

Configuration
REQ-021 With ARB_STALLCNT_EN defined, SHALL add output stall_count (16-bit), incremented each cycle core_stall=1, saturating at 0xFFFF, cleared by reset.
REQ-022 Without ARB_STALLCNT_EN, the stall_count port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-023 Core read: mem[0x0010]=0x1234, core_req=1 we=0 addr=0x0010 in IDLE cycle N -> mem_en cycle N+1, core_ack and core_rdata=0x1234 in N+2.
REQ-024 Simultaneous first requests after reset: core write 0x00AA to 0x0005, dbg read 0x0005 -> core granted first (ack N+2); dbg granted from IDLE N+3, dbg_rdata=0x00AA in N+5.
REQ-025 Both held continuously for 4 grants -> grant order core, dbg, core, dbg; core_stall=1 on every non-ack cycle of core_req.
REQ-026 halt=1 with core_req=1 and dbg_req=0 -> mem_en stays 0 and core_stall=1; dbg read 0xFFFF while halted -> served normally.
REQ-027 reset low during ISSUE of a dbg write -> mem_en=0 immediately, no dbg_ack; after release, first tie goes to core.
REQ-028 With ARB_STALLCNT_EN, core_req held through one dbg access then its own -> stall_count increments by the non-ack core_req cycles; forced 0xFFFF stays 0xFFFF.
